sevseg_scan_ctrl: RTL and testbench

Scan controller for a 4-digit multiplexed seven-segment display showing two signed bytes, A and B, as sign plus two hex magnitude digits each. It sits between the arithmetic logic that produces results and the shared `sevseg_decoder`. It time-shares that one decoder across four digit anodes and converts two's-complement values to sign/magnitude internally. New values are accepted through a valid/ready handshake and applied only at frame boundaries, so a frame never shows half-old, half-new values.

---
 rtl/sevseg_scan_if.sv | 9 +
 rtl/sevseg_scan_ctrl.sv | 71 +++++++
 tb/tb_sevseg_scan_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/sevseg_scan_if.sv
// sevseg_scan_if: valid/ready handshake carrying a signed {A, B} byte pair to the scan controller.
interface sevseg_scan_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] num_a;
    logic [7:0] num_b;
    modport master (output in_valid, num_a, num_b, input in_ready);
    modport slave  (input in_valid, num_a, num_b, output in_ready);
endinterface

// File: rtl/sevseg_scan_ctrl.sv
// sevseg_scan_ctrl: 4-digit multiplexed seven-segment scanner showing two signed bytes as sign + hex magnitude.
module sevseg_scan_ctrl #(
    parameter int   PRESCALE = 250,
    parameter bit   BLANK_LZ = 1,
    parameter logic led_on   = 1'b0,
    parameter logic led_off  = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    sevseg_scan_if.slave bus,
    output logic [3:0]   an,
    output logic [3:0]   nibble,
    output logic         sign_a,
    output logic         sign_b,
    output logic         frame_done
);
    localparam int CW = $clog2(PRESCALE);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [7:0]    disp_a, disp_b, pend_a, pend_b;
    logic          pend_v;
    logic          last, xfer, blank;
    logic [7:0]    m;

    function automatic logic [7:0] mag(input logic [7:0] x);
        return x[7] ? ~x + 8'd1 : x;
    endfunction

    always_comb begin
        last         = cnt == CW'(PRESCALE - 1);
        frame_done   = last && idx == 2'd3;
        bus.in_ready = !pend_v;
        xfer         = bus.in_valid && !pend_v;
        m            = mag(idx[1] ? disp_b : disp_a);
        nibble       = idx[0] ? m[7:4] : m[3:0];
        // first cycle of each slot stays dark so the previous digit never ghosts
        blank        = cnt == '0 || (BLANK_LZ && idx[0] && m[7:4] == 4'd0);
        an           = blank ? 4'b1111 : ~(4'b0001 << idx);
        sign_a       = disp_a[7] ? led_on : led_off;
        sign_b       = disp_b[7] ? led_on : led_off;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            idx    <= 2'd0;
            disp_a <= 8'h00;
            disp_b <= 8'h00;
            pend_a <= 8'h00;
            pend_b <= 8'h00;
            pend_v <= 1'b0;
        end else begin
            cnt <= last ? '0 : cnt + CW'(1);
            if (last)
                idx <= idx + 2'd1;
            if (frame_done && pend_v) begin
                disp_a <= pend_a;
                disp_b <= pend_b;
                pend_v <= 1'b0;
            end else if (frame_done && xfer) begin
                disp_a <= bus.num_a;
                disp_b <= bus.num_b;
            end else if (xfer) begin
                pend_a <= bus.num_a;
                pend_b <= bus.num_b;
                pend_v <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// tb_sevseg_scan_ctrl: directed checks of scan timing, blanking, sign/magnitude, handshake and reset.
`define CHK(t, o, e) begin total++; assert ((o) === (e)) else begin bad++; $error("FAIL %s obs=%0h exp=%0h", t, o, e); end end

module tb_sevseg_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] an1, nib1, an2, nib2;
    logic       sa1, sb1, fd1, sa2, sb2, fd2;
    int         total = 0;
    int         bad = 0;
    int         pos = 0;

    sevseg_scan_if i1 ();
    sevseg_scan_if i2 ();

    sevseg_scan_ctrl #(.PRESCALE(4), .BLANK_LZ(1), .led_on(1'b0), .led_off(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(i1.slave), .an(an1), .nibble(nib1),
        .sign_a(sa1), .sign_b(sb1), .frame_done(fd1));

    sevseg_scan_ctrl #(.PRESCALE(4), .BLANK_LZ(0), .led_on(1'b0), .led_off(1'b1)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(i2.slave), .an(an2), .nibble(nib2),
        .sign_a(sa2), .sign_b(sb2), .frame_done(fd2));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        total++;
        if ($countones(~an1) > 1 || $countones(~an2) > 1) begin
            bad++;
            $error("FAIL onehot an1=%0b an2=%0b", an1, an2);
        end
    end

    initial begin
        #100000;
        bad++;
        $error("FAIL timeout: expired wait at pos=%0d", pos);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic step();
        @(posedge clk);
        #1;
        pos = (pos + 1) % 16;
    endtask

    task automatic go(input int p);
        do step(); while (pos != p);
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b);
        i1.in_valid = v;
        i1.num_a = a;
        i1.num_b = b;
    endtask

    initial begin
        i2.in_valid = 1'b0;
        i2.num_a = 8'h00;
        i2.num_b = 8'h00;
        drive(1'b1, 8'hF6, 8'h25);
        repeat (3) begin @(posedge clk); #1; end
        pos = 0;
        `CHK("rst_an", an1, 4'b1111)
        `CHK("rst_nib", nib1, 4'h0)
        `CHK("rst_sa", sa1, 1'b1)
        `CHK("rst_sb", sb1, 1'b1)
        `CHK("rst_rdy", i1.in_ready, 1'b1)
        `CHK("rst_fd", fd1, 1'b0)
        `CHK("rst_an2", an2, 4'b1111)
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 8'h00);
        go(1);
        `CHK("f0_s0_an", an1, 4'b1110)
        `CHK("f0_s0_nib", nib1, 4'h0)
        go(5);
        `CHK("f0_s1_an", an1, 4'b1111)
        `CHK("lz0_s1_an", an2, 4'b1101)
        `CHK("lz0_s1_nib", nib2, 4'h0)
        go(9);
        `CHK("f0_s2_an", an1, 4'b1011)
        `CHK("f0_s2_nib", nib1, 4'h0)
        go(13);
        `CHK("f0_s3_an", an1, 4'b1111)
        `CHK("f0_sa", sa1, 1'b1)
        go(2);
        drive(1'b1, 8'hF6, 8'h25);
        `CHK("neg_rdy0", i1.in_ready, 1'b1)
        step();
        drive(1'b0, 8'h00, 8'h00);
        `CHK("neg_rdy1", i1.in_ready, 1'b0)
        `CHK("neg_sa_old", sa1, 1'b1)
        go(15);
        `CHK("neg_fd", fd1, 1'b1)
        step();
        `CHK("neg_c0_an", an1, 4'b1111)
        `CHK("neg_c0_nib", nib1, 4'hA)
        `CHK("neg_sa", sa1, 1'b0)
        `CHK("neg_sb", sb1, 1'b1)
        `CHK("neg_rdy2", i1.in_ready, 1'b1)
        go(3);
        `CHK("neg_s0_an", an1, 4'b1110)
        `CHK("neg_s0_nib", nib1, 4'hA)
        go(5);
        `CHK("neg_s1_an", an1, 4'b1111)
        go(9);
        `CHK("neg_s2_nib", nib1, 4'h5)
        `CHK("neg_s2_an", an1, 4'b1011)
        go(13);
        `CHK("neg_s3_nib", nib1, 4'h2)
        `CHK("neg_s3_an", an1, 4'b0111)
        go(14);
        drive(1'b1, 8'h80, 8'h00);
        step();
        drive(1'b0, 8'h00, 8'h00);
        go(1);
        `CHK("m80_s0_nib", nib1, 4'h0)
        `CHK("m80_s0_an", an1, 4'b1110)
        go(5);
        `CHK("m80_s1_nib", nib1, 4'h8)
        `CHK("m80_s1_an", an1, 4'b1101)
        `CHK("m80_sa", sa1, 1'b0)
        `CHK("m80_sb", sb1, 1'b1)
        go(2);
        drive(1'b1, 8'h11, 8'h22);
        step();
        drive(1'b1, 8'h33, 8'h44);
        `CHK("bp_rdy_a", i1.in_ready, 1'b0)
        go(15);
        `CHK("bp_rdy_b", i1.in_ready, 1'b0)
        `CHK("bp_fd", fd1, 1'b1)
        step();
        `CHK("bp_rdy_c", i1.in_ready, 1'b1)
        step();
        drive(1'b0, 8'h00, 8'h00);
        `CHK("bp_rdy_d", i1.in_ready, 1'b0)
        `CHK("bp1_s0_nib", nib1, 4'h1)
        go(5);
        `CHK("bp1_s1_nib", nib1, 4'h1)
        `CHK("bp1_s1_an", an1, 4'b1101)
        go(9);
        `CHK("bp1_s2_nib", nib1, 4'h2)
        go(1);
        `CHK("bp2_s0_nib", nib1, 4'h3)
        `CHK("bp2_rdy", i1.in_ready, 1'b1)
        go(5);
        `CHK("bp2_s1_nib", nib1, 4'h3)
        go(13);
        `CHK("bp2_s3_nib", nib1, 4'h4)
        go(15);
        drive(1'b1, 8'hFF, 8'h01);
        `CHK("byp_rdy0", i1.in_ready, 1'b1)
        `CHK("byp_fd", fd1, 1'b1)
        `CHK("byp_sa_old", sa1, 1'b1)
        step();
        drive(1'b0, 8'h00, 8'h00);
        `CHK("byp_sa", sa1, 1'b0)
        `CHK("byp_sb", sb1, 1'b1)
        `CHK("byp_rdy1", i1.in_ready, 1'b1)
        `CHK("byp_nib", nib1, 4'h1)
        go(9);
        `CHK("byp_s2_nib", nib1, 4'h1)
        go(4);
        drive(1'b1, 8'h81, 8'h82);
        step();
        drive(1'b0, 8'h00, 8'h00);
        `CHK("mr_pend", i1.in_ready, 1'b0)
        go(9);
        rst_n = 1'b0;
        step();
        pos = 0;
        `CHK("mr_an", an1, 4'b1111)
        `CHK("mr_nib", nib1, 4'h0)
        `CHK("mr_sa", sa1, 1'b1)
        `CHK("mr_sb", sb1, 1'b1)
        `CHK("mr_rdy", i1.in_ready, 1'b1)
        `CHK("mr_fd", fd1, 1'b0)
        rst_n = 1'b1;
        go(15);
        step();
        step();
        `CHK("mr_after_sa", sa1, 1'b1)
        `CHK("mr_after_nib", nib1, 4'h0)
        `CHK("mr_after_an", an1, 4'b1110)
        if (bad != 0)
            $error("FAIL summary: %0d of %0d checks failed", bad, total);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
